// File: rtl/marshal_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : marshal_pkg
//  Purpose  : Shared types and defaults for the serial frame marshaller:
//             FSM state encoding, byte type, output-buffer entry layout.
//  Revision : 1.0  initial release
// ============================================================================
package marshal_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF   = 8'h34;
  localparam int         FRAME_BYTES_DEF = 3;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_CHECK  = 2'd2
  } state_e;

  // Output buffer payload: first-of-frame flag above the data byte.
  typedef struct packed {
    logic  first;
    byte_t data;
  } buf_entry_t;

endpackage : marshal_pkg
`default_nettype wire

// File: rtl/marshal_out_buf.sv
`default_nettype none
// ============================================================================
//  Module   : marshal_out_buf
//  Purpose  : Two-entry FIFO between the frame deframer and the downstream
//             valid/ready consumer. A push into a full buffer is accepted
//             only when the head is popped in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module marshal_out_buf
  import marshal_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  buf_entry_t push_data,
  input  logic       pop,
  output buf_entry_t pop_data,
  output logic       full,
  output logic       empty
);

  buf_entry_t mem_q [2];
  buf_entry_t mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push;
  logic       do_pop;

  // Storage, pointers and occupancy; synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Next state: a pop frees the head slot, so a full buffer can still take a push.
  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Status flags; the head is forced to zero when empty so idle outputs read 0.
  always_comb begin
    full     = (count_q == 2'd2);
    empty    = (count_q == 2'd0);
    pop_data = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule : marshal_out_buf
`default_nettype wire

// File: rtl/marshal_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : marshal_frame_ctrl
//  Purpose  : LSB-first serial deframer. Hunts for SYNC_BYTE, then emits
//             FRAME_BYTES payload bytes per frame into a 2-entry output
//             buffer, re-checking the sync byte after every frame.
//  Revision : 1.0  initial release
// ============================================================================
module marshal_frame_ctrl
  import marshal_pkg::*;
#(
  parameter byte_t SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int    FRAME_BYTES = FRAME_BYTES_DEF
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       bit_valid,
  output logic [7:0] m_data,
  output logic       m_first,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       locked,
  output logic       lock_err,
  output logic       drop
);

  localparam byte_t LAST_BYTE = byte_t'(FRAME_BYTES - 1);

  state_e      state_q, state_d;
  // Only sh[7:1] is retained: bit 0 is shifted out on the very next bit,
  // before it could ever take part in a compare.
  logic [7:1]  sh_q, sh_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  byte_t       byte_cnt_q, byte_cnt_d;
  logic        lock_err_q, lock_err_d;
  logic        drop_q, drop_d;

  byte_t       nx;
  logic        byte_done;
  logic        push;
  logic        pop;
  buf_entry_t  push_entry;
  buf_entry_t  head;
  logic        buf_full;
  logic        buf_empty;

  // Window value including the bit currently presented.
  assign nx        = {serial_in, sh_q[7:1]};
  assign byte_done = bit_valid && (bit_cnt_q == 3'd7);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: shift window, counters and registered pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      lock_err_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      lock_err_q <= lock_err_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state logic: only a sampled bit can move the FSM.
  always_comb begin
    state_d = state_q;
    if (bit_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (nx == SYNC_BYTE) state_d = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (byte_done && (byte_cnt_q == LAST_BYTE)) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (byte_done) state_d = (nx == SYNC_BYTE) ? ST_LOCKED : ST_HUNT;
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Datapath next values: shift on every sampled bit, count only while locked.
  always_comb begin
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    if (bit_valid) begin
      sh_d = nx[7:1];
      case (state_q)
        ST_LOCKED: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_done) byte_cnt_d = byte_cnt_q + 8'd1;
        end
        ST_CHECK: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_done) byte_cnt_d = '0;
        end
        default: begin
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
        end
      endcase
    end
  end

  // Outputs: buffer push, error/drop pulse requests and the stream interface.
  always_comb begin
    push             = byte_done && (state_q == ST_LOCKED);
    push_entry.first = (byte_cnt_q == 8'd0);
    push_entry.data  = nx;
    m_valid          = !buf_empty;
    pop              = m_valid && m_ready;
    m_data           = head.data;
    m_first          = head.first;
    locked           = (state_q != ST_HUNT);
    lock_err         = lock_err_q;
    drop             = drop_q;
    lock_err_d       = byte_done && (state_q == ST_CHECK) && (nx != SYNC_BYTE);
    drop_d           = push && buf_full && !pop;
  end

  marshal_out_buf u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (buf_full),
    .empty     (buf_empty)
  );

endmodule : marshal_frame_ctrl
`default_nettype wire

// File: tb/tb_marshal_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_marshal_frame_ctrl
//  Purpose  : Scoreboard bench for marshal_frame_ctrl: directed scenarios and
//             randomized bit streams against a bit-position reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_marshal_frame_ctrl;

  localparam logic [7:0] SYNC = 8'h34;
  localparam int         FB   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_first;
  logic       m_valid;
  logic       locked;
  logic       lock_err;
  logic       drop;

  always #5 clk = ~clk;

  marshal_frame_ctrl #(.SYNC_BYTE(SYNC), .FRAME_BYTES(FB)) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .bit_valid (bit_valid),
    .m_data    (m_data),
    .m_first   (m_first),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .locked    (locked),
    .lock_err  (lock_err),
    .drop      (drop)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: sync window, lock flag, bit position since lock.
  bit         md_locked;
  int         md_pos;
  logic [7:0] md_win;
  bit         md_lock_err;
  bit         md_drop;
  logic [8:0] mb[$];      // model of buffer occupancy
  logic [8:0] exp_q[$];   // scoreboard of bytes the DUT must deliver
  logic [7:0] obs_q[$];   // delivered bytes, for literal scenario checks
  bit         mon_en = 1'b0;
  int         n_out = 0;
  int         n_lockerr = 0;
  int         n_drop = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    md_locked   = 1'b0;
    md_pos      = 0;
    md_win      = 8'h00;
    md_lock_err = 1'b0;
    md_drop     = 1'b0;
    mb.delete();
    exp_q.delete();
  endfunction

  // One clock edge of the reference model, given the inputs sampled there.
  function automatic void model_step(input bit bv, input bit sb, input bit rdy);
    logic [8:0] prod;
    bit         have;
    bit         pop;
    bit         was_full;
    int         idx;
    have        = 1'b0;
    prod        = '0;
    md_lock_err = 1'b0;
    md_drop     = 1'b0;
    pop         = rdy && (mb.size() > 0);
    was_full    = (mb.size() == 2);
    if (bv) begin
      md_win = {sb, md_win[7:1]};
      if (!md_locked) begin
        if (md_win == SYNC) begin
          md_locked = 1'b1;
          md_pos    = 0;
        end
      end else begin
        idx    = md_pos;
        md_pos = md_pos + 1;
        if (idx < FB * 8) begin
          if (idx % 8 == 7) begin
            have = 1'b1;
            prod = {(idx == 7), md_win};
          end
        end else if (idx == FB * 8 + 7) begin
          if (md_win == SYNC) md_pos = 0;
          else begin
            md_locked   = 1'b0;
            md_lock_err = 1'b1;
          end
        end
      end
    end
    if (pop) void'(mb.pop_front());
    if (have) begin
      if (was_full && !pop) md_drop = 1'b1;
      else begin
        mb.push_back(prod);
        exp_q.push_back(prod);
      end
    end
  endfunction

  // Monitor: compares flags every cycle and pops the scoreboard on each handshake.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("m_valid", m_valid, mb.size() != 0);
        chk("locked", locked, md_locked);
        chk("lock_err", lock_err, md_lock_err);
        chk("drop", drop, md_drop);
        if (lock_err) n_lockerr++;
        if (drop) n_drop++;
        if (m_valid && m_ready) begin
          n_out++;
          obs_q.push_back(m_data);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h expected none at %0t", m_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("m_data", m_data, e[7:0]);
            chk("m_first", m_first, e[8]);
          end
        end
      end
    end
  end

  // Drive inputs for one edge; called just after a rising edge.
  task automatic cyc(input bit bv, input bit sb, input bit rdy);
    bit_valid = bv;
    serial_in = sb;
    m_ready   = rdy;
    @(posedge clk);
    model_step(bv, sb, rdy);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    bit_valid = 1'b0;
    serial_in = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_first", m_first, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lock_err", lock_err, 0);
    chk("rst_drop", drop, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit sparse, input bit rdy);
    for (int i = 0; i < 8; i++) begin
      if (sparse) cyc(1'b0, 1'b0, rdy);
      cyc(1'b1, b[i], rdy);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, rdy);
  endtask

  task automatic send_frame(input bit sparse, input bit rdy);
    logic [31:0] w;
    w = 32'hABCD1234;
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], sparse, rdy);
  endtask

  task automatic check_obs(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input int n);
    chk({name, "_count"}, obs_q.size(), n);
    if (n > 0 && obs_q.size() > 0) chk({name, "_b0"}, obs_q[0], a);
    if (n > 1 && obs_q.size() > 1) chk({name, "_b1"}, obs_q[1], b);
    if (n > 2 && obs_q.size() > 2) chk({name, "_b2"}, obs_q[2], c);
  endtask

  initial begin
    int lerr0;
    int drp0;
    int out0;
    logic [7:0] b;
    repeat (2) @(posedge clk);
    #1;

    // Scenario: basic frame, continuous bits, always ready.
    do_reset();
    obs_q.delete();
    send_byte(8'h34, 1'b0, 1'b1);
    chk("s1_locked_after_sync", locked, 1);
    send_byte(8'h12, 1'b0, 1'b1);
    chk("s1_first_valid", m_valid, 1);
    chk("s1_first_data", m_data, 8'h12);
    chk("s1_first_flag", m_first, 1);
    send_byte(8'hCD, 1'b0, 1'b1);
    send_byte(8'hAB, 1'b0, 1'b1);
    idle(4, 1'b1);
    check_obs("s1", 8'h12, 8'hCD, 8'hAB, 3);
    chk("s1_drained", exp_q.size(), 0);

    // Scenario: resync byte keeps lock and restarts the frame.
    send_byte(8'h34, 1'b0, 1'b1);
    chk("s2_locked_kept", locked, 1);
    obs_q.delete();
    send_byte(8'h5A, 1'b0, 1'b1);
    idle(2, 1'b1);
    chk("s2_next_first_data", obs_q.size() > 0 ? obs_q[0] : 8'hxx, 8'h5A);

    // Scenario: bad sync byte after a frame.
    do_reset();
    send_frame(1'b0, 1'b1);
    lerr0 = n_lockerr;
    send_byte(8'h00, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("s2b_lock_err_pulses", n_lockerr - lerr0, 1);
    chk("s2b_unlocked", locked, 0);

    // Scenario: downstream stalled throughout -> third byte dropped.
    do_reset();
    obs_q.delete();
    drp0 = n_drop;
    send_frame(1'b0, 1'b0);
    idle(5, 1'b0);
    chk("s3_drop_pulses", n_drop - drp0, 1);
    chk("s3_held_valid", m_valid, 1);
    chk("s3_held_head", m_data, 8'h12);
    idle(5, 1'b1);
    check_obs("s3", 8'h12, 8'hCD, 8'h00, 2);

    // Scenario: bits every other cycle.
    do_reset();
    obs_q.delete();
    send_frame(1'b1, 1'b1);
    idle(4, 1'b1);
    check_obs("s4", 8'h12, 8'hCD, 8'hAB, 3);

    // Scenario: reset in the middle of a frame, then a clean resend.
    do_reset();
    obs_q.delete();
    send_byte(8'h34, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, (i == 1), 1'b1);
    do_reset();
    send_frame(1'b0, 1'b1);
    idle(4, 1'b1);
    check_obs("s5", 8'h12, 8'hCD, 8'hAB, 3);

    // Scenario: all ones never locks.
    do_reset();
    lerr0 = n_lockerr;
    drp0  = n_drop;
    out0  = n_out;
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b1, 1'b1);
    chk("s6_locked", locked, 0);
    chk("s6_lock_err", n_lockerr - lerr0, 0);
    chk("s6_drop", n_drop - drp0, 0);
    chk("s6_outputs", n_out - out0, 0);

    // Randomized streams: sync-rich bytes, random gaps and backpressure.
    for (int ph = 0; ph < 2; ph++) begin
      do_reset();
      for (int n = 0; n < 160; n++) begin
        b = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
        for (int i = 0; i < 8; i++) begin
          while ($urandom_range(0, 3) == 0)
            cyc(1'b0, 1'($urandom), (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
          cyc(1'b1, b[i], (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
        end
      end
      idle(6, 1'b1);
      chk("rand_drained", exp_q.size(), 0);
    end

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_marshal_frame_ctrl
`default_nettype wire

// File: doc/marshal_frame_ctrl.md
MARSHAL_FRAME_CTRL -- requirements
Module: marshal_frame_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, default 8'h34: frame sync byte, compared LSB-first.
REQ-002 Parameter FRAME_BYTES, default 3: payload bytes per frame, range 1..255.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-low.
REQ-005 serial_in  in  1  serial data bit, LSB-first.
REQ-006 bit_valid  in  1  serial_in is sampled only when high.
REQ-007 m_data  out  8  payload byte at buffer head.
REQ-008 m_first  out  1  m_data is payload byte 0 of its frame.
REQ-009 m_valid  out  1  buffer head valid.
REQ-010 m_ready  in  1  downstream accepts the head when m_valid and m_ready are both high.
REQ-011 locked  out  1  high when state is not HUNT.
REQ-012 lock_err  out  1  one-cycle pulse on a sync mismatch in CHECK.
REQ-013 drop  out  1  one-cycle pulse when a completed payload byte is discarded because the buffer is full.

Function
REQ-014 Shift register sh[7:0] SHALL update on bit_valid as sh <= {serial_in, sh[7:1]}; the next value nx = {serial_in, sh[7:1]}.
REQ-015 With bit_valid low, no register other than the output buffer pop logic SHALL change.
REQ-016 States SHALL be HUNT, LOCKED and CHECK.
REQ-017 HUNT: on bit_valid, nx == SYNC_BYTE -> LOCKED with bit_cnt=0 and byte_cnt=0; otherwise remain in HUNT, evaluating every bit.
REQ-018 LOCKED: bit_cnt SHALL increment on each bit_valid and wrap 7->0; on the bit with bit_cnt==7, nx SHALL be pushed with first=(byte_cnt==0).
REQ-019 LOCKED: at that same bit, byte_cnt SHALL increment; if byte_cnt==FRAME_BYTES-1, the state SHALL go to CHECK with bit_cnt=0.
REQ-020 CHECK: collect 8 bits; on the 8th, nx == SYNC_BYTE -> LOCKED with counters cleared and no push.
REQ-021 CHECK: on the 8th bit, a mismatch -> HUNT with a lock_err pulse in the following cycle; hunting resumes from the next bit.
REQ-022 Latency: a pushed byte SHALL appear on m_data with m_valid high in the cycle after the edge that samples its 8th bit, provided the buffer was empty.
REQ-023 The output buffer SHALL hold 2 entries, be FIFO-ordered, and hold m_data/m_first stable while m_valid && !m_ready.
REQ-024 Push when full and no pop in the same cycle: the byte SHALL be discarded and drop SHALL pulse; buffer contents are unchanged.
REQ-025 Push when full with a pop in the same cycle: the push SHALL be accepted without a drop.
REQ-026 Push and pop in the same cycle when empty is not possible, because the pushed byte is registered first.
REQ-027 Counters SHALL be sized exactly: bit_cnt 3 bits; byte_cnt 8 bits.

Reset
REQ-028 While rst is low at a clock edge, the block SHALL reset to: state HUNT, sh=0, bit_cnt=0, byte_cnt=0, buffer empty.
REQ-029 Outputs after reset SHALL be: m_valid=0, m_first=0, m_data=0, locked=0, lock_err=0, drop=0.
REQ-030 A reset mid-frame SHALL discard all partial and buffered data; no output is produced for that frame.

Structure
REQ-031 Package marshal_pkg SHALL hold the state enum, the byte typedef, and the SYNC_BYTE/FRAME_BYTES defaults.
REQ-032 The 2-entry buffer SHALL be sub-module marshal_out_buf, with a 9-bit payload {first, data} and push/pop/full/empty ports.

Verification
REQ-033 Scenario: reset, then 32'hABCD1234 sent LSB-first with bit_valid=1 continuously and m_ready=1 -> locked rises after bit 8; outputs are 8'h12 (first=1), 8'hCD, 8'hAB, each m_valid for 1 cycle, the first in the cycle after bit 16.
REQ-034 Scenario: scenario 1 followed by byte 8'h34 -> locked stays 1 and the next payload byte has first=1; followed instead by 8'h00 -> lock_err pulses once and locked=0.
REQ-035 Scenario: scenario 1 with m_ready=0 throughout -> buffer holds 12, CD; AB is dropped with one drop pulse; raising m_ready then yields 12, CD in order.
REQ-036 Scenario: scenario 1 with bit_valid high every other cycle -> identical output bytes and flags.
REQ-037 Scenario: rst low for 1 cycle after bit 12 -> next cycle locked=0 and m_valid=0; resending scenario 1 produces the normal output.
REQ-038 Scenario: 64 bits of all ones -> locked, m_valid, lock_err and drop stay 0.
